dm_responder: RTL and testbench

- Data-memory responder for the CPU's load/store path; answers each memory request with a req/ready handshake.
- Holds a word-organised RAM and supports word, half and byte stores.
- Supports word, signed and unsigned half, and signed and unsigned byte loads, plus a configurable wait-state count.
- Lets the datapath move from a combinational DM to a stallable memory interface.

---
 rtl/dm_responder.sv | 198 +++++++++++++++++++
 tb/tb_dm_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder answering load/store requests over a req/ready handshake.
// Define DM_WRITE_LOG_EN to print a trace line for every successful store.
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [3:0]             cnt_r;
    logic                   we_r;
    logic [2:0]             op_r;
    logic [31:0]            addr_r;
    logic [31:0]            wdata_r;
    logic [31:0]            pc_r;
    logic                   ready_r;
    logic                   err_r;
    logic [31:0]            rdata_r;

    // A word not written since reset reads as zero, which gives a one-edge RAM clear.
    logic [31:0]            mem_r [DEPTH];
    logic [DEPTH-1:0]       valid_r;

    logic [ADDR_WIDTH-1:0]  idx_s;
    logic [31:0]            old_word_s;
    logic [31:0]            merged_s;
    logic [31:0]            load_s;
    logic                   bad_s;
    logic                   access_s;
    logic                   write_s;
    logic                   unused_s;

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] data,
                                               input logic [2:0] kind, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] ins;
        logic [4:0]  sh;
        mask = 32'h0000_0000;
        ins  = 32'h0000_0000;
        sh   = 5'd0;
        case (kind)
            3'b000: begin
                mask = 32'hFFFF_FFFF;
                ins  = data;
                sh   = 5'd0;
            end
            3'b001, 3'b010: begin
                mask = 32'h0000_FFFF;
                ins  = {16'h0000, data[15:0]};
                sh   = {lane[1], 4'b0000};
            end
            3'b011, 3'b100: begin
                mask = 32'h0000_00FF;
                ins  = {24'h00_0000, data[7:0]};
                sh   = {lane, 3'b000};
            end
            default: begin
                mask = 32'h0000_0000;
                ins  = 32'h0000_0000;
                sh   = 5'd0;
            end
        endcase
        return (old & ~(mask << sh)) | (ins << sh);
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [2:0] kind,
                                                 input logic [1:0] lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (kind)
            3'b000:  result = word;
            3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  result = {16'h0000, shifted[15:0]};
            3'b011:  result = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  result = {24'h00_0000, shifted[7:0]};
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    // Address decode, alignment check and lane merge/extract for the latched request
    always_comb begin
        idx_s      = addr_r[ADDR_WIDTH+1:2];
        old_word_s = valid_r[idx_s] ? mem_r[idx_s] : 32'h0000_0000;
        bad_s      = 1'b1;
        case (op_r)
            3'b000:         bad_s = (addr_r[1:0] != 2'b00);
            3'b001, 3'b010: bad_s = addr_r[0];
            3'b011, 3'b100: bad_s = 1'b0;
            default:        bad_s = 1'b1;
        endcase
        merged_s = merge_word(old_word_s, wdata_r, op_r, addr_r[1:0]);
        load_s   = extract_lane(old_word_s, op_r, addr_r[1:0]);
        access_s = (state_r == BUSY) && (cnt_r == 4'd0);
        write_s  = access_s && we_r && !bad_s;
    end

    // pc only feeds the optional trace and upper address bits wrap away.
    assign unused_s = ^{pc_r, addr_r[31:ADDR_WIDTH+2]};

    // RAM data array, written by a successful store on its access edge
    always_ff @(posedge clk) begin
        if (write_s && !reset) begin
            mem_r[idx_s] <= merged_s;
`ifdef DM_WRITE_LOG_EN
            $display("@%08h: *%08h <= %08h", pc_r, {addr_r[31:2], 2'b00}, merged_s);
`endif
        end
    end

    // Per-word written flags, cleared together on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else if (write_s) begin
            valid_r[idx_s] <= 1'b1;
        end
    end

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            op_r    <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            pc_r    <= 32'h0000_0000;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    if (req) begin
                        we_r    <= we;
                        op_r    <= op;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        pc_r    <= pc;
                        cnt_r   <= WAIT_INIT;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        ready_r <= 1'b1;
                        err_r   <= bad_s;
                        rdata_r <= (we_r || bad_s) ? 32'h0000_0000 : load_s;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign rdata = rdata_r;
    assign err   = err_r;
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a WAIT_CYCLES=2 instance for functional cases and
// a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dm_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_req, a_we, a_ready, a_err;
    logic [2:0]  a_op;
    logic [31:0] a_addr, a_wdata, a_pc, a_rdata;
    logic        b_req, b_we, b_ready, b_err;
    logic [2:0]  b_op;
    logic [31:0] b_addr, b_wdata, b_pc, b_rdata;

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .we(a_we), .op(a_op), .addr(a_addr),
        .wdata(a_wdata), .pc(a_pc), .ready(a_ready), .rdata(a_rdata), .err(a_err)
    );

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .we(b_we), .op(b_op), .addr(b_addr),
        .wdata(b_wdata), .pc(b_pc), .ready(b_ready), .rdata(b_rdata), .err(b_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            check("a_pulse_width", {31'd0, a_prev}, 32'd0);
            if (q_a.size() == 0) begin
                flag("a_unexpected_ready");
            end else begin
                ea = q_a.pop_front();
                check({ea.name, "_rdata"}, a_rdata, ea.rdata);
                check({ea.name, "_err"}, {31'd0, a_err}, {31'd0, ea.err});
                check({ea.name, "_latency"}, cyc, ea.due);
            end
        end
        a_prev <= a_ready;
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (b_ready === 1'b1) begin
            check("b_pulse_width", {31'd0, b_prev}, 32'd0);
            if (q_b.size() == 0) begin
                flag("b_unexpected_ready");
            end else begin
                eb = q_b.pop_front();
                check({eb.name, "_rdata"}, b_rdata, eb.rdata);
                check({eb.name, "_err"}, {31'd0, b_err}, {31'd0, eb.err});
                check({eb.name, "_cycle"}, cyc, eb.due);
            end
        end
        b_prev <= b_ready;
    end

    task automatic do_a(input logic w, input logic [2:0] o, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string name);
        exp_t e;
        logic got;
        e.rdata = exp_rd; e.err = exp_err; e.due = cyc + 4; e.name = name;
        q_a.push_back(e);
        a_req = 1'b1; a_we = w; a_op = o; a_addr = ad; a_wdata = wd; a_pc = 32'h0000_3000;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = a_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no ready expected ready", name);
            q_a.delete();
        end
        a_req = 1'b0;
        @(negedge clk);
    endtask

    // Keeps req high on return so the next call forms a back-to-back request.
    task automatic do_b(input logic w, input logic [2:0] o, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                        input string name);
        exp_t e;
        logic got;
        e.rdata = exp_rd; e.err = 1'b0; e.due = cyc + lat; e.name = name;
        q_b.push_back(e);
        b_req = 1'b1; b_we = w; b_op = o; b_addr = ad; b_wdata = wd;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = b_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no ready expected ready", name);
            q_b.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_op = 3'b000; a_addr = 32'h0; a_wdata = 32'h0; a_pc = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_op = 3'b000; b_addr = 32'h0; b_wdata = 32'h0; b_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_a_err", {31'd0, a_err}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back on the zero-wait instance: one response every 3 cycles
        do_b(1'b1, 3'b000, 32'h0000_0008, 32'h1122_3344, 32'h0000_0000, 2, "b2b_sw");
        do_b(1'b0, 3'b000, 32'h0000_0008, 32'h0,         32'h1122_3344, 3, "b2b_lw");
        do_b(1'b0, 3'b100, 32'h0000_0009, 32'h0,         32'h0000_0033, 3, "b2b_lbu");
        b_req = 1'b0;
        @(negedge clk);

        do_a(1'b1, 3'b000, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0, "sw");
        do_a(1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, "lw");
        do_a(1'b1, 3'b001, 32'h0000_0012, 32'h1111_BEEF, 32'h0000_0000, 1'b0, "sh");
        do_a(1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hBEEF_5678, 1'b0, "lw_after_sh");
        do_a(1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0, "lh");
        do_a(1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0, "lhu");
        do_a(1'b1, 3'b011, 32'h0000_0013, 32'h1234_5680, 32'h0000_0000, 1'b0, "sb");
        do_a(1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'h80EF_5678, 1'b0, "lw_after_sb");
        do_a(1'b0, 3'b011, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, "lb");
        do_a(1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, "lbu");
        do_a(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h0000_5678, 1'b0, "lhu_low");

        do_a(1'b1, 3'b000, 32'h0000_0022, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, "sw_misaligned");
        do_a(1'b0, 3'b000, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b0, "lw_0x20_kept");
        do_a(1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, "lh_misaligned");
        do_a(1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, "op_reserved");
        do_a(1'b1, 3'b111, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "st_reserved");
        do_a(1'b0, 3'b000, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b0, "lw_0x20_still");

        do_a(1'b1, 3'b000, 32'h0000_4010, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0, "sw_alias");
        do_a(1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hA5A5_5A5A, 1'b0, "lw_alias");

        // reset while the store is still waiting in BUSY
        a_req = 1'b1; a_we = 1'b1; a_op = 3'b000; a_addr = 32'h0000_0040; a_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, a_ready}, 32'd0);
        check("midrst_rdata", a_rdata, 32'd0);
        check("midrst_err", {31'd0, a_err}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        do_a(1'b0, 3'b000, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0, "lw_0x40_after_rst");
        do_a(1'b0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, "lw_0x10_cleared");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
